// File: rtl/seq_mul_pkg.sv
// ---------------------------------------------------------------------------
// seq_mul_pkg - shared types and helpers for the shift-add multiplier. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_mul_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_mul_dp.sv
// ---------------------------------------------------------------------------
// seq_mul_dp - accumulator/shift register with a WIDTH+1-bit add/sub. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_mul_dp #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               last_i,
  input  logic               sgn_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             sgn_q, sgn_d;
  logic [WIDTH:0]   w_ext_hi;
  logic [WIDTH:0]   w_ext_a;
  logic [WIDTH:0]   w_sum;

  // In signed mode the extra bit is a sign extension, otherwise it holds the carry.
  assign w_ext_hi = {sgn_q & hi_q[WIDTH-1], hi_q};
  assign w_ext_a  = {sgn_q & mcand_q[WIDTH-1], mcand_q};

  always_comb begin
    w_sum = w_ext_hi;
    if (lo_q[0]) begin
      // The multiplier MSB carries negative weight in two's complement.
      if (sgn_q && last_i) w_sum = w_ext_hi - w_ext_a;
      else                 w_sum = w_ext_hi + w_ext_a;
    end
  end

  always_comb begin
    hi_d    = hi_q;
    lo_d    = lo_q;
    mcand_d = mcand_q;
    sgn_d   = sgn_q;
    if (load_i) begin
      hi_d    = '0;
      lo_d    = b_i;
      mcand_d = a_i;
      sgn_d   = sgn_i;
    end else if (step_i) begin
      hi_d = w_sum[WIDTH:1];
      lo_d = {w_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      sgn_q   <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mcand_q <= mcand_d;
      sgn_q   <= sgn_d;
    end
  end

  assign acc_o = {hi_q, lo_q};

endmodule

`default_nettype wire

// File: rtl/seq_shift_add_multiplier.sv
// ---------------------------------------------------------------------------
// seq_shift_add_multiplier - one bit per clock shift-add multiplier, valid/ready I/O. Rev 1.0
// Optional SEQ_MUL_SIGNED_EN adds signed_op for two's-complement operands.
// ---------------------------------------------------------------------------
`default_nettype none

module seq_shift_add_multiplier
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
`ifdef SEQ_MUL_SIGNED_EN
  input  logic               signed_op,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int             CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            w_accept;
  logic            w_step;
  logic            w_last;
  logic            w_sgn;

`ifdef SEQ_MUL_SIGNED_EN
  assign w_sgn = signed_op;
`else
  assign w_sgn = 1'b0;
`endif

  // Ready is forced low while reset is asserted, not just while in IDLE.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign w_accept  = in_valid && in_ready;
  assign w_step    = (state_q == CALC);
  assign w_last    = w_step && (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (w_accept) begin
        state_d = CALC;
        cnt_d   = '0;
      end
      CALC: begin
        if (w_last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  seq_mul_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (w_accept),
    .step_i (w_step),
    .last_i (w_last),
    .sgn_i  (w_sgn),
    .a_i    (a),
    .b_i    (b),
    .acc_o  (product)
  );

endmodule

`default_nettype wire
